// File: rtl/instr_encoder_if.sv
// Handshake bundle for the instruction encoder: field-tuple input channel,
// packed-word output channel and FIFO occupancy.
interface instr_encoder_if #(
    parameter int PTR_W = 2
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_fmt;
    logic [6:0]       in_opcode;
    logic [2:0]       in_funct3;
    logic [6:0]       in_funct7;
    logic [4:0]       in_rd;
    logic [4:0]       in_rs1;
    logic [4:0]       in_rs2;
    logic [31:0]      in_imm;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_instr;
    logic             out_err;
    logic [PTR_W:0]   count;

    modport slave (
        input  in_valid, in_fmt, in_opcode, in_funct3, in_funct7,
               in_rd, in_rs1, in_rs2, in_imm, out_ready,
        output in_ready, out_valid, out_instr, out_err, count
    );

    modport master (
        output in_valid, in_fmt, in_opcode, in_funct3, in_funct7,
               in_rd, in_rs1, in_rs2, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, out_err, count
    );
endinterface

// File: rtl/instr_encoder.sv
// Packs RV32I field tuples into 32-bit instruction words and queues them in a
// small FIFO whose head is held in dedicated output registers.
module instr_encoder #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic           clk,
    input  logic           rst,
    instr_encoder_if.slave bus
);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    // Returns {err, word}; B/J keep packing with imm[0] dropped when flagged.
    function automatic logic [32:0] pack_instr(
        input logic [2:0]  fmt,
        input logic [6:0]  op,
        input logic [2:0]  f3,
        input logic [6:0]  f7,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [31:0] imm
    );
        logic [31:0] w;
        logic        e;
        w = '0;
        e = 1'b0;
        case (fmt)
            FMT_R: w = {f7, rs2, rs1, f3, rd, op};
            FMT_I: w = {imm[11:0], rs1, f3, rd, op};
            FMT_S: w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
            FMT_B: begin
                w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
                e = imm[0];
            end
            FMT_U: w = {imm[31:12], rd, op};
            FMT_J: begin
                w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
                e = imm[0];
            end
            default: begin
                w = '0;
                e = 1'b1;
            end
        endcase
        return {e, w};
    endfunction

    logic [32:0]    mem_q [DEPTH];
    logic [32:0]    mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [31:0]      out_instr_q, out_instr_d;
    logic             out_err_q, out_err_d;

    logic        in_ready;
    logic        out_valid;
    logic        push;
    logic        pop;
    logic [32:0] new_entry;
    logic [32:0] head_entry;

    always_comb begin
        in_ready  = (count_q != FULL_CNT);
        out_valid = (count_q != '0);
        push      = bus.in_valid && in_ready;
        pop       = out_valid && bus.out_ready;
        new_entry = pack_instr(bus.in_fmt, bus.in_opcode, bus.in_funct3, bus.in_funct7,
                               bus.in_rd, bus.in_rs1, bus.in_rs2, bus.in_imm);

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) begin
            mem_d[wr_ptr_q] = new_entry;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase

        // Next head: an entry landing exactly at the new read slot is taken
        // straight from the packer, since the array write is not visible yet.
        head_entry = mem_q[rd_ptr_d];
        if (push && (wr_ptr_q == rd_ptr_d)) begin
            head_entry = new_entry;
        end
        out_instr_d = out_instr_q;
        out_err_d   = out_err_q;
        if (count_d != '0) begin
            out_instr_d = head_entry[31:0];
            out_err_d   = head_entry[32];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_instr_q <= '0;
            out_err_q   <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_instr_q <= out_instr_d;
            out_err_q   <= out_err_d;
        end
    end

    // Storage array is unreset; stale slots are never exposed past the pointers.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_instr = out_instr_q;
    assign bus.out_err   = out_err_q;
    assign bus.count     = count_q;
endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: hand-packed RV32I words, FIFO fill/drain,
// simultaneous accept/pop, illegal format and mid-run reset.
module tb_instr_encoder;
    logic clk = 1'b0;
    logic rst;
    int   total  = 0;
    int   passed = 0;

    instr_encoder_if #(.PTR_W(2)) bus ();

    instr_encoder #(.DEPTH(4), .PTR_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic set_tuple(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                             input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                             input logic [4:0] rs2, input logic [31:0] imm);
        bus.in_valid  = 1'b1;
        bus.in_fmt    = fmt;
        bus.in_opcode = op;
        bus.in_funct3 = f3;
        bus.in_funct7 = f7;
        bus.in_rd     = rd;
        bus.in_rs1    = rs1;
        bus.in_rs2    = rs2;
        bus.in_imm    = imm;
    endtask

    initial begin
        rst           = 1'b1;
        bus.out_ready = 1'b0;
        set_tuple(3'd0, 7'h0, 3'd0, 7'h0, 5'd0, 5'd0, 5'd0, 32'h0);
        bus.in_valid  = 1'b0;
        tick;
        tick;
        rst = 1'b0;
        tick;
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_instr", bus.out_instr, 32'h0);
        chk("rst_out_err", 32'(bus.out_err), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // R-format add x3,x1,x2
        set_tuple(3'd0, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'h0);
        chk("add_no_bypass", 32'(bus.out_valid), 32'd0);
        tick;
        bus.in_valid = 1'b0;
        chk("add_valid", 32'(bus.out_valid), 32'd1);
        chk("add_word", bus.out_instr, 32'h002081B3);
        chk("add_err", 32'(bus.out_err), 32'd0);
        chk("add_count", 32'(bus.count), 32'd1);
        bus.out_ready = 1'b1;
        tick;
        chk("add_popped", 32'(bus.out_valid), 32'd0);
        chk("empty_hold", bus.out_instr, 32'h002081B3);

        // Back-to-back with consumer always ready
        set_tuple(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5);
        tick;
        chk("addi_word", bus.out_instr, 32'h00500093);
        chk("addi_count", 32'(bus.count), 32'd1);
        set_tuple(3'd2, 7'h23, 3'd2, 7'h00, 5'd0, 5'd1, 5'd2, 32'd8);
        tick;
        chk("sw_word", bus.out_instr, 32'h0020A423);
        chk("sw_count", 32'(bus.count), 32'd1);
        set_tuple(3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'd8);
        tick;
        chk("beq_word", bus.out_instr, 32'h00208463);
        set_tuple(3'd4, 7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h12345000);
        tick;
        chk("lui_word", bus.out_instr, 32'h123452B7);
        chk("lui_err", 32'(bus.out_err), 32'd0);
        set_tuple(3'd5, 7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'h800);
        tick;
        chk("jal_word", bus.out_instr, 32'h001000EF);
        chk("jal_err", 32'(bus.out_err), 32'd0);
        set_tuple(3'd5, 7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'h801);
        tick;
        chk("jal_odd_word", bus.out_instr, 32'h001000EF);
        chk("jal_odd_err", 32'(bus.out_err), 32'd1);
        bus.in_valid = 1'b0;
        tick;
        chk("drained", 32'(bus.count), 32'd0);

        // Fill with addi x1,x0,k for k=1..4, then hold the fifth
        bus.out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            set_tuple(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'(k));
            tick;
        end
        chk("full_count", 32'(bus.count), 32'd4);
        chk("full_in_ready", 32'(bus.in_ready), 32'd0);
        chk("full_head", bus.out_instr, 32'h00100093);
        set_tuple(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5);
        tick;
        chk("fifth_held_count", 32'(bus.count), 32'd4);
        chk("fifth_held_head", bus.out_instr, 32'h00100093);
        bus.out_ready = 1'b1;
        tick;
        bus.out_ready = 1'b0;
        chk("pop_at_full_count", 32'(bus.count), 32'd3);
        chk("pop_at_full_ready", 32'(bus.in_ready), 32'd1);
        chk("pop_at_full_head", bus.out_instr, 32'h00200093);
        tick;
        bus.in_valid = 1'b0;
        chk("fifth_accepted", 32'(bus.count), 32'd4);
        chk("stall_hold", bus.out_instr, 32'h00200093);
        bus.out_ready = 1'b1;
        tick;
        chk("order_3", bus.out_instr, 32'h00300093);
        tick;
        chk("order_4", bus.out_instr, 32'h00400093);
        chk("order_4_count", 32'(bus.count), 32'd2);

        // Accept and pop together at count=2
        set_tuple(3'd0, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'h0);
        tick;
        bus.in_valid = 1'b0;
        chk("simul_count", 32'(bus.count), 32'd2);
        chk("simul_head", bus.out_instr, 32'h00500093);
        tick;
        chk("simul_next", bus.out_instr, 32'h002081B3);
        chk("simul_next_count", 32'(bus.count), 32'd1);
        tick;
        chk("final_empty", 32'(bus.out_valid), 32'd0);

        // Illegal format, then reset with three words queued
        bus.out_ready = 1'b0;
        set_tuple(3'd7, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'h0);
        tick;
        chk("illegal_word", bus.out_instr, 32'h0);
        chk("illegal_err", 32'(bus.out_err), 32'd1);
        tick;
        tick;
        chk("pre_rst_count", 32'(bus.count), 32'd3);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        chk("mid_rst_count", 32'(bus.count), 32'd0);
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_ready", 32'(bus.in_ready), 32'd1);
        chk("mid_rst_instr", bus.out_instr, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the instruction field decoder. Accepts per-field instruction descriptions (format, opcode, funct3, funct7, rd, rs1, rs2, immediate) over a valid/ready handshake.
- Packs each description into a 32-bit RV32I instruction word and buffers the words in a small FIFO.
- Emits the words over a second valid/ready handshake.
- Used by the debug/self-test path to inject instructions into instruction memory or the fetch stage.

Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2.
- PTR_W, 2, log2(DEPTH).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  field tuple valid.
- in_ready  output  1  encoder can accept a tuple.
- in_fmt  input  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6,7 illegal.
- in_opcode  input  7  opcode field.
- in_funct3  input  3  funct3 field.
- in_funct7  input  7  funct7 field.
- in_rd  input  5  destination register.
- in_rs1  input  5  source register 1.
- in_rs2  input  5  source register 2.
- in_imm  input  32  immediate, byte-offset semantics for B/J, upper-value semantics for U.
- out_valid  output  1  head FIFO word valid.
- out_ready  input  1  consumer accepts word.
- out_instr  output  32  packed instruction word.
- out_err  output  1  error flag stored with the word.
- count  output  PTR_W+1  current FIFO occupancy.

Behaviour:
- Clocking: single clock; all state updates on the rising edge of clk; rst is synchronous and active-high.
- Reset: write/read pointers=0, count=0, out_valid=0, out_instr=0, out_err=0, in_ready=1 in the cycle after reset deasserts. rst asserted mid-operation discards all buffered words immediately; any accept in that cycle is ignored.
- Accept: occurs when in_valid && in_ready. in_ready = (count != DEPTH), combinational from count only.
- Packing (combinational, written into the FIFO on accept):
  - R: funct7[31:25] rs2[24:20] rs1[19:15] funct3[14:12] rd[11:7] opcode[6:0].
  - I: imm[11:0]→[31:20], rs1, funct3, rd, opcode.
  - S: imm[11:5]→[31:25], rs2, rs1, funct3, imm[4:0]→[11:7], opcode.
  - B: imm[12]→[31], imm[10:5]→[30:25], rs2, rs1, funct3, imm[4:1]→[11:8], imm[11]→[7], opcode.
  - U: imm[31:12]→[31:12], rd, opcode.
  - J: imm[20]→[31], imm[10:1]→[30:21], imm[11]→[20], imm[19:12]→[19:12], rd, opcode.
  - Fields unused by the selected format are ignored. Immediate bits above the encodable range are silently dropped.
- Error flag (stored per entry):
  - Set if in_fmt ∈ {6,7}; the word is then 32'h00000000.
  - Set if fmt is B or J and imm[0]=1; the word is still packed with imm[0] dropped.
  - Otherwise 0.
- Output:
  - FIFO head is registered; out_valid = (count != 0).
  - Latency: a tuple accepted at edge N into an empty FIFO appears on out_instr/out_err after edge N, i.e. visible in cycle N+1.
  - No combinational in→out bypass.
- Pop: occurs when out_valid && out_ready. out_instr/out_err hold stable while out_valid && !out_ready.
- Simultaneous accept and pop: count is unchanged and both pointers advance. At count=DEPTH, in_ready=0, so no accept occurs even if a pop happens that cycle; in_ready rises the cycle after.
- Pointers wrap modulo DEPTH.
- Pop with count=0 cannot occur because out_valid=0. Accept with count=DEPTH cannot occur because in_ready=0.
- When empty, out_instr/out_err keep their last values; consumers must qualify with out_valid.

Test Plan:
- Reset, then R-format ADD: opcode=0x33, f3=0, f7=0, rd=3, rs1=1, rs2=2 → out_instr=0x002081B3, out_err=0, visible one cycle after accept.
- Back-to-back, out_ready=1:
  - I addi x1,x0,5 → 0x00500093.
  - S sw x2,8(x1): opcode=0x23, f3=2 → 0x0020A423.
  - B beq x1,x2,+8: opcode=0x63 → 0x00208463.
  - Words arrive in order, one per cycle.
- U lui x5,0x12345000 → 0x123452B7. J jal x1, imm=0x800 → 0x001000EF. J with imm=0x801 → 0x001000EF, out_err=1.
- Fill: hold out_ready=0 and push 5 tuples → after 4 accepts in_ready=0, count=4. The fifth tuple is held. Assert out_ready for one cycle → first word popped; fifth accepted the cycle after in_ready rises; order preserved.
- With count=2, accept and pop in the same cycle → count stays 2, head advances to next word.
- in_fmt=7 → out_instr=0x00000000, out_err=1. rst asserted with count=3 → next cycle count=0, out_valid=0, in_ready=1.
